// File: rtl/y86_pkg.sv
// y86_pkg -- constants shared by the Y86-64 pipeline stages.
//   * instruction codes (icode), stage status codes (stat), RNONE
//   * alu_fn_e: operation selector for the alu_w sub-module
//   * cond_eval(): jXX / cmovXX condition from a {ZF,SF,OF} flag set
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] I_IADDQ  = 4'hC;

  // Stage status codes
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  // "No register" destination ID
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fn_e;

  // True when a later stage holds an exception that must freeze the flags.
  function automatic logic stat_blocks_cc(input logic [2:0] stat);
    return (stat == S_ADR) || (stat == S_INS) || (stat == S_HLT);
  endfunction

  // Standard Y86 conditions; cc = {ZF,SF,OF}. Codes above 6 are never true.
  function automatic logic cond_eval(input logic [2:0] cc, input logic [3:0] ifun);
    logic zf, sf, of, lt;
    zf = cc[2];
    sf = cc[1];
    of = cc[0];
    lt = sf ^ of;
    case (ifun)
      4'd0:    return 1'b1;       // always
      4'd1:    return lt | zf;    // le
      4'd2:    return lt;         // l
      4'd3:    return zf;         // e
      4'd4:    return ~zf;        // ne
      4'd5:    return ~lt;        // ge
      4'd6:    return ~lt & ~zf;  // g
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_w.sv
// alu_w -- Y86 ALU, purely combinational, computes "b op a".
//   a, b    in  WIDTH  operands (b is the left-hand operand of sub)
//   fn      in  alu_fn_e operation
//   result  out WIDTH  two's complement result modulo 2^WIDTH
//   zf/sf/of out 1     zero, sign, signed overflow (of=0 for and/xor)
module alu_w
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_fn_e          fn,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    result = '0;
    of     = 1'b0;
    case (fn)
      ALU_ADD: begin
        result = b + a;
        // Overflow: operands share a sign that the result does not.
        of = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != b[WIDTH-1]);
      end
      ALU_SUB: begin
        result = b - a;
        // Overflow: operands differ in sign and result sign differs from b.
        of = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != b[WIDTH-1]);
      end
      ALU_AND: result = b & a;
      ALU_XOR: result = b ^ a;
      default: result = '0;
    endcase
    zf = (result == '0);
    sf = result[WIDTH-1];
  end

endmodule

// File: rtl/pipe_execute.sv
// pipe_execute -- Y86-64 execute stage plus the E/M pipeline register.
//   clk, rst_n           clock; synchronous active-low reset
//   E_*                  decoded instruction from the E register
//   m_stat, W_stat       later-stage status, freezes CC on exceptions
//   M_stall, M_bubble    M register hold / nop injection (bubble wins)
//   e_valE/e_dstE/e_Cnd  zero-latency results for forwarding
//   M_*                  registered E/M pipeline register
//   cc_q                 condition codes {ZF,SF,OF}
// Optional feature: define EXEC_IADDQ_EN to execute iaddq (icode C).
module pipe_execute
  import y86_pkg::*;
#(
  parameter int WIDTH = 64  // minimum 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       E_stat,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_ifun,
  input  logic [WIDTH-1:0] E_valC,
  input  logic [WIDTH-1:0] E_valA,
  input  logic [WIDTH-1:0] E_valB,
  input  logic [3:0]       E_dstE,
  input  logic [3:0]       E_dstM,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  input  logic             M_stall,
  input  logic             M_bubble,
  output logic [WIDTH-1:0] e_valE,
  output logic [3:0]       e_dstE,
  output logic             e_Cnd,
  output logic [2:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_Cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM,
  output logic [2:0]       cc_q
);

  // Stack pointer adjustment: one machine word.
  localparam logic [WIDTH-1:0] STEP = WIDTH'(WIDTH / 8);

  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  alu_fn_e          alu_fn;
  logic             alu_zf, alu_sf, alu_of;
  logic             val_en;   // icode produces a real e_valE
  logic             cc_op;    // icode is allowed to write CC
  logic             set_cc;
  logic [2:0]       cc_d;

  // ---------------- operand / function selection ----------------
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_fn = ALU_ADD;
    val_en = 1'b1;
    cc_op  = 1'b0;
    case (E_icode)
      I_OPQ: begin
        alu_a  = E_valA;
        alu_b  = E_valB;
        alu_fn = alu_fn_e'(E_ifun[1:0]);
        cc_op  = 1'b1;
      end
      I_RRMOVQ: alu_a = E_valA;
      I_IRMOVQ: alu_a = E_valC;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a = E_valC;
        alu_b = E_valB;
      end
      I_CALL, I_PUSHQ: begin
        alu_a  = STEP;
        alu_b  = E_valB;
        alu_fn = ALU_SUB;
      end
      I_RET, I_POPQ: begin
        alu_a = STEP;
        alu_b = E_valB;
      end
`ifdef EXEC_IADDQ_EN
      I_IADDQ: begin
        alu_a = E_valC;
        alu_b = E_valB;
        cc_op = 1'b1;
      end
`endif
      default: val_en = 1'b0;
    endcase
  end

  alu_w #(.WIDTH(WIDTH)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .fn     (alu_fn),
    .result (alu_result),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  // ---------------- combinational stage outputs ----------------
  always_comb begin
    e_valE = val_en ? alu_result : '0;
    // Condition uses the committed flags, never this cycle's ALU flags.
    e_Cnd  = ((E_icode == I_RRMOVQ) || (E_icode == I_JXX)) ? cond_eval(cc_q, E_ifun) : 1'b0;
    // A cmov whose condition fails must not write its destination.
    e_dstE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? RNONE : E_dstE;
    // A faulting instruction (here or downstream) must not change the flags.
    set_cc = cc_op && (E_stat == S_AOK) && !stat_blocks_cc(m_stat) && !stat_blocks_cc(W_stat);
    cc_d   = set_cc ? {alu_zf, alu_sf, alu_of} : cc_q;
  end

  // ---------------- E/M register next state ----------------
  logic [2:0]       m_stat_d,  m_stat_q;
  logic [3:0]       m_icode_d, m_icode_q;
  logic             m_cnd_d,   m_cnd_q;
  logic [WIDTH-1:0] m_vale_d,  m_vale_q;
  logic [WIDTH-1:0] m_vala_d,  m_vala_q;
  logic [3:0]       m_dste_d,  m_dste_q;
  logic [3:0]       m_dstm_d,  m_dstm_q;

  always_comb begin
    // Default: hold (covers M_stall).
    m_stat_d  = m_stat_q;
    m_icode_d = m_icode_q;
    m_cnd_d   = m_cnd_q;
    m_vale_d  = m_vale_q;
    m_vala_d  = m_vala_q;
    m_dste_d  = m_dste_q;
    m_dstm_d  = m_dstm_q;
    if (M_bubble) begin
      m_stat_d  = S_AOK;
      m_icode_d = I_NOP;
      m_cnd_d   = 1'b0;
      m_vale_d  = '0;
      m_vala_d  = '0;
      m_dste_d  = RNONE;
      m_dstm_d  = RNONE;
    end else if (!M_stall) begin
      m_stat_d  = E_stat;
      m_icode_d = E_icode;
      m_cnd_d   = e_Cnd;
      m_vale_d  = e_valE;
      m_vala_d  = E_valA;
      m_dste_d  = e_dstE;
      m_dstm_d  = E_dstM;
    end
  end

  // Reset loads the same nop a bubble would, discarding any stalled contents.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      cc_q      <= 3'b100;
      m_stat_q  <= S_AOK;
      m_icode_q <= I_NOP;
      m_cnd_q   <= 1'b0;
      m_vale_q  <= '0;
      m_vala_q  <= '0;
      m_dste_q  <= RNONE;
      m_dstm_q  <= RNONE;
    end else begin
      cc_q      <= cc_d;
      m_stat_q  <= m_stat_d;
      m_icode_q <= m_icode_d;
      m_cnd_q   <= m_cnd_d;
      m_vale_q  <= m_vale_d;
      m_vala_q  <= m_vala_d;
      m_dste_q  <= m_dste_d;
      m_dstm_q  <= m_dstm_d;
    end
  end

  assign M_stat  = m_stat_q;
  assign M_icode = m_icode_q;
  assign M_Cnd   = m_cnd_q;
  assign M_valE  = m_vale_q;
  assign M_valA  = m_vala_q;
  assign M_dstE  = m_dste_q;
  assign M_dstM  = m_dstm_q;

endmodule

// File: tb/tb_pipe_execute.sv
// tb_pipe_execute -- directed bench for pipe_execute (WIDTH=64 and WIDTH=32).
module tb_pipe_execute;
  import y86_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 64-bit instance
  logic [2:0]  E_stat, m_stat, W_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valC, E_valA, E_valB;
  logic        M_stall, M_bubble;
  logic [63:0] e_valE, M_valE, M_valA;
  logic [3:0]  e_dstE, M_icode, M_dstE, M_dstM;
  logic        e_Cnd, M_Cnd;
  logic [2:0]  M_stat, cc_q;

  pipe_execute #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat),
    .M_stall(M_stall), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .cc_q(cc_q)
  );

  // 32-bit instance (wrap-around check)
  logic [3:0]  n_icode;
  logic [31:0] n_valB, n_valE, n_M_valE, n_M_valA;
  logic [3:0]  n_dstE, n_M_icode, n_M_dstE, n_M_dstM;
  logic        n_Cnd, n_M_Cnd;
  logic [2:0]  n_M_stat, n_cc_q;

  pipe_execute #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .E_stat(S_AOK), .E_icode(n_icode), .E_ifun(4'h0),
    .E_valC(32'h0), .E_valA(32'h0), .E_valB(n_valB),
    .E_dstE(4'h4), .E_dstM(RNONE),
    .m_stat(S_AOK), .W_stat(S_AOK),
    .M_stall(1'b0), .M_bubble(1'b0),
    .e_valE(n_valE), .e_dstE(n_dstE), .e_Cnd(n_Cnd),
    .M_stat(n_M_stat), .M_icode(n_M_icode), .M_Cnd(n_M_Cnd),
    .M_valE(n_M_valE), .M_valA(n_M_valA), .M_dstE(n_M_dstE), .M_dstM(n_M_dstM),
    .cc_q(n_cc_q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] valC, input logic [63:0] valA,
                       input logic [63:0] valB, input logic [3:0] dstE);
    E_icode = icode; E_ifun = ifun;
    E_valC  = valC;  E_valA = valA; E_valB = valB;
    E_dstE  = dstE;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; M_stall = 1'b1; M_bubble = 1'b0;
    E_stat = S_INS; m_stat = S_AOK; W_stat = S_AOK; E_dstM = 4'h2;
    n_icode = I_NOP; n_valB = '0;
    drive(I_OPQ, 4'h0, 64'h0, 64'h1, 64'h1, 4'h3);
    tick();
    checks++; if (cc_q !== 3'b100) begin errors++; $display("FAIL reset_cc got %b want 100", cc_q); end
    checks++; if (M_icode !== I_NOP) begin errors++; $display("FAIL reset_icode got %h want 1", M_icode); end
    checks++; if (M_dstE !== RNONE) begin errors++; $display("FAIL reset_dstE got %h want f", M_dstE); end
    checks++; if (M_stat !== S_AOK) begin errors++; $display("FAIL reset_stat got %h want 1", M_stat); end
    rst_n = 1'b1; M_stall = 1'b0; E_stat = S_AOK;
  endtask

  task automatic test_subq();
    drive(I_OPQ, 4'h1, 64'h0, 64'd5, 64'd3, 4'h3);
    checks++; if (e_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL subq_valE got %h want fffffffffffffffe", e_valE); end
    checks++; if (e_dstE !== 4'h3) begin errors++; $display("FAIL subq_dstE got %h want 3", e_dstE); end
    tick();
    checks++; if (cc_q !== 3'b010) begin errors++; $display("FAIL subq_cc got %b want 010", cc_q); end
    checks++; if (M_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL subq_MvalE got %h want fffffffffffffffe", M_valE); end
    checks++; if (M_icode !== I_OPQ) begin errors++; $display("FAIL subq_Micode got %h want 6", M_icode); end
    drive(I_JXX, 4'h2, 64'h40, 64'h0, 64'h0, RNONE);
    checks++; if (e_Cnd !== 1'b1) begin errors++; $display("FAIL jl_cnd got %b want 1", e_Cnd); end
    drive(I_JXX, 4'h5, 64'h40, 64'h0, 64'h0, RNONE);
    checks++; if (e_Cnd !== 1'b0) begin errors++; $display("FAIL jge_cnd got %b want 0", e_Cnd); end
    drive(I_JXX, 4'h7, 64'h40, 64'h0, 64'h0, RNONE);
    checks++; if (e_Cnd !== 1'b0) begin errors++; $display("FAIL jifun7_cnd got %b want 0", e_Cnd); end
    drive(I_OPQ, 4'h2, 64'h0, 64'h0, 64'h0, 4'h3);
    checks++; if (e_Cnd !== 1'b0) begin errors++; $display("FAIL opq_cnd got %b want 0", e_Cnd); end
  endtask

  task automatic test_overflow();
    drive(I_OPQ, 4'h0, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h1);
    checks++; if (e_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL addq_ovf_valE got %h want fffffffffffffffe", e_valE); end
    tick();
    checks++; if (cc_q !== 3'b011) begin errors++; $display("FAIL addq_ovf_cc got %b want 011", cc_q); end
  endtask

  task automatic test_cc_suppress();
    // subq 5-5 -> cc 100, then each suppressed addq must leave it alone.
    drive(I_OPQ, 4'h1, 64'h0, 64'd5, 64'd5, 4'h1);
    tick();
    checks++; if (cc_q !== 3'b100) begin errors++; $display("FAIL subq_zero_cc got %b want 100", cc_q); end
    m_stat = S_ADR;
    drive(I_OPQ, 4'h0, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h1);
    tick();
    checks++; if (cc_q !== 3'b100) begin errors++; $display("FAIL supp_mstat_cc got %b want 100", cc_q); end
    m_stat = S_AOK; W_stat = S_HLT;
    tick();
    checks++; if (cc_q !== 3'b100) begin errors++; $display("FAIL supp_wstat_cc got %b want 100", cc_q); end
    W_stat = S_AOK; E_stat = S_INS;
    tick();
    checks++; if (cc_q !== 3'b100) begin errors++; $display("FAIL supp_estat_cc got %b want 100", cc_q); end
    checks++; if (M_stat !== S_INS) begin errors++; $display("FAIL supp_estat_Mstat got %h want 4", M_stat); end
    E_stat = S_AOK;
  endtask

  task automatic test_cmov_push();
    // cc = 100 (ZF=1): cmovne fails, cmove succeeds
    drive(I_RRMOVQ, 4'h4, 64'h0, 64'h55, 64'h0, 4'h5);
    checks++; if (e_dstE !== RNONE) begin errors++; $display("FAIL cmovne_dstE got %h want f", e_dstE); end
    checks++; if (e_valE !== 64'h55) begin errors++; $display("FAIL cmovne_valE got %h want 55", e_valE); end
    tick();
    checks++; if (M_dstE !== RNONE) begin errors++; $display("FAIL cmovne_MdstE got %h want f", M_dstE); end
    checks++; if (M_valA !== 64'h55) begin errors++; $display("FAIL cmovne_MvalA got %h want 55", M_valA); end
    drive(I_RRMOVQ, 4'h3, 64'h0, 64'h55, 64'h0, 4'h5);
    checks++; if (e_dstE !== 4'h5 || e_Cnd !== 1'b1) begin errors++; $display("FAIL cmove_dstE_cnd got %h/%b want 5/1", e_dstE, e_Cnd); end
    drive(I_MRMOVQ, 4'h0, 64'h10, 64'h0, 64'h20, RNONE);
    checks++; if (e_valE !== 64'h30) begin errors++; $display("FAIL mrmovq_valE got %h want 30", e_valE); end
    drive(I_IRMOVQ, 4'h0, 64'h1234, 64'h0, 64'h99, 4'h2);
    checks++; if (e_valE !== 64'h1234) begin errors++; $display("FAIL irmovq_valE got %h want 1234", e_valE); end
    drive(I_HALT, 4'h0, 64'h1234, 64'h7, 64'h99, 4'h2);
    checks++; if (e_valE !== 64'h0) begin errors++; $display("FAIL halt_valE got %h want 0", e_valE); end
    drive(I_PUSHQ, 4'h0, 64'h0, 64'h0, 64'h100, 4'h4);
    checks++; if (e_valE !== 64'hF8) begin errors++; $display("FAIL pushq_valE got %h want f8", e_valE); end
    drive(I_POPQ, 4'h0, 64'h0, 64'h0, 64'h100, 4'h4);
    checks++; if (e_valE !== 64'h108) begin errors++; $display("FAIL popq_valE got %h want 108", e_valE); end
  endtask

  task automatic test_stall_bubble();
    drive(I_PUSHQ, 4'h0, 64'h0, 64'h0, 64'h100, 4'h4);
    tick();
    checks++; if (M_valE !== 64'hF8) begin errors++; $display("FAIL push_MvalE got %h want f8", M_valE); end
    // Stall two edges while an xorq (1^0 -> cc 000) sits in E.
    M_stall = 1'b1;
    drive(I_OPQ, 4'h3, 64'h0, 64'h1, 64'h0, 4'h6);
    tick();
    tick();
    checks++; if (M_valE !== 64'hF8 || M_icode !== I_PUSHQ) begin errors++; $display("FAIL stall_hold got %h/%h want f8/a", M_valE, M_icode); end
    checks++; if (cc_q !== 3'b000) begin errors++; $display("FAIL stall_cc got %b want 000", cc_q); end
    M_bubble = 1'b1;
    tick();
    checks++; if (M_icode !== I_NOP || M_valE !== 64'h0 || M_dstE !== RNONE || M_dstM !== RNONE) begin
      errors++; $display("FAIL stall_bubble got %h/%h/%h/%h want 1/0/f/f", M_icode, M_valE, M_dstE, M_dstM);
    end
    // Reset in the middle of a stall discards held irmovq contents.
    M_stall = 1'b0; M_bubble = 1'b0;
    drive(I_IRMOVQ, 4'h0, 64'h1234, 64'h0, 64'h0, 4'h2);
    tick();
    checks++; if (M_valE !== 64'h1234) begin errors++; $display("FAIL irmov_MvalE got %h want 1234", M_valE); end
    M_stall = 1'b1; rst_n = 1'b0;
    tick();
    checks++; if (M_icode !== I_NOP || M_valE !== 64'h0 || cc_q !== 3'b100) begin
      errors++; $display("FAIL reset_in_stall got %h/%h/%b want 1/0/100", M_icode, M_valE, cc_q);
    end
    rst_n = 1'b1; M_stall = 1'b0;
  endtask

  task automatic test_width32();
    n_icode = I_POPQ; n_valB = 32'hFFFF_FFFC;
    #1;
    checks++; if (n_valE !== 32'h0) begin errors++; $display("FAIL w32_popq_valE got %h want 0", n_valE); end
    n_icode = I_PUSHQ; n_valB = 32'h0;
    #1;
    checks++; if (n_valE !== 32'hFFFF_FFFC) begin errors++; $display("FAIL w32_pushq_valE got %h want fffffffc", n_valE); end
  endtask

  task automatic test_iaddq();
    logic [63:0] exp_val;
    logic [2:0]  exp_cc;
`ifdef EXEC_IADDQ_EN
    exp_val = 64'd3; exp_cc = 3'b000;
`else
    exp_val = 64'd0; exp_cc = 3'b100;
`endif
    // cc is 100 from the preceding reset
    drive(I_IADDQ, 4'h0, 64'd2, 64'h0, 64'd1, 4'h7);
    checks++; if (e_valE !== exp_val) begin errors++; $display("FAIL iaddq_valE got %h want %h", e_valE, exp_val); end
    checks++; if (e_dstE !== 4'h7 || e_Cnd !== 1'b0) begin errors++; $display("FAIL iaddq_dstE_cnd got %h/%b want 7/0", e_dstE, e_Cnd); end
    tick();
    checks++; if (cc_q !== exp_cc) begin errors++; $display("FAIL iaddq_cc got %b want %b", cc_q, exp_cc); end
  endtask

  initial begin
    test_reset();
    test_subq();
    test_overflow();
    test_cc_suppress();
    test_cmov_push();
    test_stall_bubble();
    test_width32();
    test_iaddq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_execute.md
PIPE_EXECUTE -- requirements
Module: pipe_execute

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set the datapath width in bits for valA, valB, valC and valE, with a minimum of 16.
REQ-002 Clock and reset are decided: one clock, clk; reset rst_n is synchronous and active-low.
REQ-003 The ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- E_stat  in  3  stage status
- E_icode  in  4  instruction code
- E_ifun  in  4  function code
- E_valC / E_valA / E_valB  in  WIDTH  operands
- E_dstE / E_dstM  in  4  destination register IDs
- m_stat / W_stat  in  3  status of later stages, used for CC suppression
- M_stall  in  1  hold the M register
- M_bubble  in  1  load a nop into the M register
- e_valE  out  WIDTH  combinational ALU result, for forwarding
- e_dstE  out  4  combinational destination after cmov gating
- e_Cnd  out  1  combinational condition
- M_stat / M_icode / M_Cnd / M_valE / M_valA / M_dstE / M_dstM  out  registered E/M pipeline register
- cc_q  out  3  registered flags {ZF,SF,OF}

Function
REQ-010 ALU operand selection and operation by E_icode SHALL be:
- OPq (6): valB op valA; ifun 0=add, 1=sub (valB-valA), 2=and, 3=xor.
- rrmovq/cmovXX (2): valA+0.
- irmovq (3): valC+0.
- rmmovq/mrmovq (4,5): valB+valC.
- call/pushq (8,A): valB-STEP.
- ret/popq (9,B): valB+STEP.
- All other icodes: e_valE=0.
REQ-011 STEP SHALL equal WIDTH/8, and all arithmetic SHALL be two's complement modulo 2^WIDTH.
REQ-012 The flags SHALL be computed as: ZF = result==0; SF = result[WIDTH-1]; OF = signed overflow of the performed add or sub (0 for and/xor).
REQ-013 set_cc SHALL equal (E_icode==OPq) && m_stat not in {ADR,INS,HLT} && W_stat not in {ADR,INS,HLT}.
REQ-014 cc_q SHALL load the new flags on the rising clk edge only when set_cc is 1.
REQ-015 e_Cnd SHALL be derived from cc_q (not the flags being computed this cycle) for ifun 0..6: always, le, l, e, ne, ge, g, using the standard Y86 equations.
REQ-016 e_Cnd SHALL be 0 for ifun above 6 and for any icode other than 2 or 7.
REQ-017 e_dstE SHALL equal RNONE (4'hF) when E_icode==2 and e_Cnd==0, and E_dstE otherwise.
REQ-018 e_valE, e_dstE and e_Cnd SHALL be valid in the same cycle as their inputs (zero latency); the M_* outputs SHALL follow one clk later.
REQ-019 On each edge the M register SHALL:
- if M_bubble=1, load a nop: stat AOK, icode NOP(1), Cnd 0, valE 0, valA 0, dstE/dstM RNONE;
- else if M_stall=1, hold its value;
- else load {E_stat, E_icode, e_Cnd, e_valE, E_valA, e_dstE, E_dstM}.
REQ-020 When M_bubble and M_stall are both 1, bubble SHALL take priority.
REQ-021 The cc_q update SHALL be independent of M_stall and M_bubble.
REQ-022 When E_stat is not AOK, cc_q SHALL NOT be updated, and the M register SHALL load E_stat normally.

Reset
REQ-030 When rst_n=0 at a clk edge, cc_q SHALL become 3'b100 and the M register SHALL take the REQ-019 nop values.
REQ-031 Reset SHALL override M_stall, M_bubble and set_cc.
REQ-032 A reset asserted in the middle of a stall SHALL discard the held contents.

Configuration
REQ-040 With macro EXEC_IADDQ_EN defined, icode C (iaddq) SHALL compute valB+valC, SHALL set CC under the same suppression rule as OPq, and SHALL pass e_dstE unchanged.
REQ-041 Without EXEC_IADDQ_EN, icode C SHALL behave as an unknown icode: e_valE=0, no CC update, e_Cnd=0.

Structure
REQ-050 The icode, stat and RNONE constants and the ALU function enum SHALL live in the shared package y86_pkg.
REQ-051 The ALU SHALL be a sub-module, alu_w (parameter WIDTH), that outputs result, zf, sf and of; all registers and control SHALL stay in pipe_execute.

Verification
REQ-060 The bench SHALL cover these directed scenarios (WIDTH=64 unless stated):
- Reset: after rst_n=0 for one edge, cc_q=100, M_icode=1, M_dstE=F, M_stat=AOK.
- subq: valA=5, valB=3 -> e_valE=FFFF_FFFF_FFFF_FFFE; next edge cc_q=010; a following jl gives e_Cnd=1 and jge gives e_Cnd=0.
- Signed overflow: addq with valA=valB=7FFF_FFFF_FFFF_FFFF -> cc_q=011.
- CC suppression: same addq with m_stat=ADR -> cc_q unchanged.
- cmovne with ZF=1 -> e_dstE=F and M_dstE=F; pushq with valB=100 -> e_valE=F8.
- M_stall=1 for 2 cycles holds the M register; M_stall=1 with M_bubble=1 gives a nop.
- WIDTH=32 popq with valB=FFFF_FFFC -> e_valE=0 (wrap-around).
- iaddq with valB=1, valC=2: e_valE=3 with EXEC_IADDQ_EN defined, and 0 without it.
